pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core. Drives the stall/flush controls of the F/D, D/E and E/M pipeline registers and the PC redirect mux.
- Detects and orders three event classes:
  - Tuse/Tnew data hazards.
  - Multiply/divide unit (MDU) occupancy, tracked by an internal busy countdown.
  - Exception requests and eret.
- Keeps a saturating stall-cycle performance counter and a sticky stall-watchdog flag.

Parameters:
- MULT_LAT, 5, busy cycles loaded for mult/multu.
- DIV_LAT, 10, busy cycles loaded for div/divu.
- EXC_VEC, 32'h0000_4180, exception handler entry PC.
- MAX_STALL, 64, consecutive stall cycles before stall_timeout sets.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high; clock clk.
- d_rs  in  5  D-stage rs index.
- d_rt  in  5  D-stage rt index.
- d_tuse_rs  in  2  cycles until D instruction consumes rs (3 = unused).
- d_tuse_rt  in  2  same, for rt.
- d_is_md  in  1  D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- d_is_eret  in  1  D instruction is eret.
- e_wa  in  5  E-stage destination register.
- e_tnew  in  2  E-stage cycles until result ready.
- m_wa  in  5  M-stage destination register.
- m_tnew  in  2  M-stage cycles until result ready.
- md_start  in  1  E-stage mult/div issuing this cycle.
- md_op  in  1  0 = mult class, 1 = div class.
- exc_req  in  1  M-stage exception/interrupt taken.
- epc  in  32  current EPC value.
- stall  out  1  hold PC and F/D; bubble D/E.
- fd_flush  out  1  clear F/D.
- de_flush  out  1  clear D/E.
- em_flush  out  1  clear E/M.
- pc_redirect  out  1  select pc_target for next PC.
- pc_target  out  32  redirect address.
- md_busy  out  1  MDU occupied.
- stall_cnt  out  32  total stall cycles since reset.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Combinational outputs:
  - stall, fd_flush, de_flush, em_flush, pc_redirect and pc_target are combinational from the current inputs and registered state.
  - While rst = 1 all of them are forced to 0.
- Data hazard:
  - haz_rs = (d_rs != 0) && ((d_rs == e_wa && e_tnew > d_tuse_rs) || (d_rs == m_wa && m_tnew > d_tuse_rs)).
  - haz_rt is identical using d_rt and d_tuse_rt.
  - Register $0 never hazards.
- MDU hazard: haz_md = d_is_md && md_busy.
- Stall and flush equations:
  - stall = (haz_rs | haz_rt | haz_md) & ~exc_req. An exception always overrides a stall.
  - de_flush = stall | exc_req.
  - em_flush = exc_req.
  - fd_flush = exc_req | (d_is_eret & ~stall). An eret that is stalled is not flushed until the stall clears.
- Redirect:
  - If exc_req: pc_redirect = 1, pc_target = EXC_VEC.
  - Else if d_is_eret & ~stall: pc_redirect = 1, pc_target = epc.
  - Otherwise pc_redirect = 0 and pc_target = 0.
- MDU counter (md_cnt, 4 bits wide enough for DIV_LAT):
  - Reset value is 0.
  - On md_start & ~exc_req, load MULT_LAT or DIV_LAT according to md_op.
  - Otherwise, if md_cnt != 0, decrement by 1.
  - md_start coincident with exc_req is dropped: the E instruction is being flushed.
  - exc_req while md_cnt != 0 does not cancel the count; the issued operation completes.
  - md_busy = (md_cnt != 0) | md_start. Its reset value is 0.
- stall_cnt:
  - Reset value is 0.
  - Increments every cycle in which stall = 1.
  - Saturates at 32'hFFFF_FFFF.
- run counter:
  - Reset value is 0.
  - Increments while stall = 1 and clears to 0 on any cycle with stall = 0.
- stall_timeout:
  - Reset value is 0.
  - Sets when the run counter reaches MAX_STALL.
  - Once set, only rst clears it.
- Reset mid-operation: rst clears md_cnt, stall_cnt, the run counter and stall_timeout on the next edge, regardless of the inputs.

Decomposition:
- Shared package (cpu_defs) holds:
  - MULT_LAT, DIV_LAT and EXC_VEC as defaults.
  - TUSE_NONE = 2'd3.
  - The 2-bit Tuse/Tnew encoding.
- One sub-module, md_busy_tracker, contains md_cnt and its load/decrement logic and outputs md_busy.
- The hazard, flush and redirect logic and the counters stay in the top module.

Test Plan:
- Load-use hazard:
  - Stimulus: d_rs = 8, d_tuse_rs = 0, e_wa = 8, e_tnew = 2.
  - Response: stall = 1, de_flush = 1, fd_flush = 0.
  - Then set e_tnew = 0: stall = 0.
- Register $0:
  - Stimulus: d_rs = 0, e_wa = 0, e_tnew = 2.
  - Response: stall = 0.
- div busy:
  - Stimulus: md_start = 1 with md_op = 1, one cycle; then d_is_md = 1.
  - Response: md_busy = 1 on the md_start cycle and for the 10 following cycles; stall = 1 throughout; stall = 0 on cycle 11; stall_cnt = 11.
- Exception overrides stall:
  - Stimulus: hazard active and exc_req = 1, together with md_start = 1.
  - Response: stall = 0, fd_flush = de_flush = em_flush = 1, pc_redirect = 1, pc_target = 32'h4180, md_cnt stays 0.
- eret:
  - Stimulus: d_is_eret = 1, epc = 32'h3008, no hazard.
  - Response: fd_flush = 1, pc_target = 32'h3008.
  - With a hazard also active: fd_flush = 0 and pc_redirect = 0 until the hazard clears.
- Watchdog:
  - Stimulus: hold a hazard for 64 cycles.
  - Response: stall_timeout = 1 and stays 1 after the hazard drops; rst clears stall_timeout and stall_cnt to 0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the 5-stage MIPS pipeline control.
package cpu_defs;

    // Tuse/Tnew are 2-bit cycle counts; Tuse of 3 marks an operand the instruction never reads.
    typedef logic [1:0] tstage_t;

    localparam tstage_t TUSE_NONE = 2'd3;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

    localparam int unsigned MD_CNT_W = 4;

endpackage

// File: rtl/md_busy_tracker.sv
// Multiply/divide unit occupancy countdown.
module md_busy_tracker
    import cpu_defs::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    input  logic md_op,
    input  logic exc_req,
    output logic md_busy
);

    logic [MD_CNT_W-1:0] md_cnt;
    logic [MD_CNT_W-1:0] md_cnt_nxt;

    // Load on issue (a flushed issue is dropped), otherwise count down to idle.
    always_comb begin
        md_cnt_nxt = md_cnt;
        if (md_start && !exc_req) begin
            md_cnt_nxt = md_op ? MD_CNT_W'(DIV_LAT) : MD_CNT_W'(MULT_LAT);
        end else if (md_cnt != '0) begin
            md_cnt_nxt = md_cnt - MD_CNT_W'(1);
        end
    end

    // Countdown register.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt <= '0;
        end else begin
            md_cnt <= md_cnt_nxt;
        end
    end

    // The issue cycle itself already counts as busy.
    assign md_busy = ~rst & ((md_cnt != '0) | md_start);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: hazard stalls, flushes, PC redirect and stall statistics.
module pipe_hazard_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned MULT_LAT  = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT   = DIV_LAT_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
    parameter int unsigned MAX_STALL = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_is_md,
    input  logic        d_is_eret,
    input  logic [4:0]  e_wa,
    input  logic [1:0]  e_tnew,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  m_tnew,
    input  logic        md_start,
    input  logic        md_op,
    input  logic        exc_req,
    input  logic [31:0] epc,
    output logic        stall,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        em_flush,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        md_busy,
    output logic [31:0] stall_cnt,
    output logic        stall_timeout
);

    localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);

    logic             haz_rs;
    logic             haz_rt;
    logic             haz_md;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_cnt_nxt;

    md_busy_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy (
        .clk      (clk),
        .rst      (rst),
        .md_start (md_start),
        .md_op    (md_op),
        .exc_req  (exc_req),
        .md_busy  (md_busy)
    );

    // Operand hazards: producer in E or M will not have its result ready by the time D needs it.
    always_comb begin
        haz_rs = (d_rs != 5'd0) && (tstage_t'(d_tuse_rs) != TUSE_NONE) &&
                 (((d_rs == e_wa) && (e_tnew > d_tuse_rs)) ||
                  ((d_rs == m_wa) && (m_tnew > d_tuse_rs)));
        haz_rt = (d_rt != 5'd0) && (tstage_t'(d_tuse_rt) != TUSE_NONE) &&
                 (((d_rt == e_wa) && (e_tnew > d_tuse_rt)) ||
                  ((d_rt == m_wa) && (m_tnew > d_tuse_rt)));
        haz_md = d_is_md && md_busy;
    end

    // Stall/flush/redirect; an exception overrides any stall, a stalled eret waits.
    always_comb begin
        stall       = 1'b0;
        fd_flush    = 1'b0;
        de_flush    = 1'b0;
        em_flush    = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = 32'h0;
        if (!rst) begin
            stall    = (haz_rs | haz_rt | haz_md) & ~exc_req;
            de_flush = stall | exc_req;
            em_flush = exc_req;
            fd_flush = exc_req | (d_is_eret & ~stall);
            if (exc_req) begin
                pc_redirect = 1'b1;
                pc_target   = EXC_VEC;
            end else if (d_is_eret && !stall) begin
                pc_redirect = 1'b1;
                pc_target   = epc;
            end
        end
    end

    // Consecutive-stall run length, saturating at the watchdog threshold.
    always_comb begin
        run_cnt_nxt = '0;
        if (stall) begin
            run_cnt_nxt = (run_cnt >= RUN_W'(MAX_STALL)) ? run_cnt : run_cnt + RUN_W'(1);
        end
    end

    // Stall statistics: saturating total, run length and sticky watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt     <= 32'h0;
            run_cnt       <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            run_cnt <= run_cnt_nxt;
            if (run_cnt_nxt >= RUN_W'(MAX_STALL)) begin
                stall_timeout <= 1'b1;
            end
        end
    end

endmodule
